adc_capture: RTL and testbench

- Downstream consumer of the 4-channel ADC front end (adc1/adc2/adc4/adc8, 16-bit each) in the CLKDIV domain.
- Arms on request, waits for a software or level-crossing trigger, then stores a block of consecutive 4-channel samples in on-chip RAM.
- Streams the stored block out over a valid/ready interface to the host/readout logic.
- Captures are gated by the frame-alignment flag, so no unaligned data is ever stored.

---
 rtl/adc_pkg.sv | 23 ++
 rtl/adc_capture_if.sv | 17 +
 rtl/capture_ram.sv | 27 ++
 rtl/adc_capture.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_capture.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_pkg.sv
// Shared types for the ADC capture block: FSM states and the packed 4-channel word.
// No logic; imported by the RTL and the bench.
package adc_pkg;

    localparam int ADC_DATA_W = 16;
    localparam int NUM_CH     = 4;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE,
        READOUT
    } cap_state_t;

    // ch0 sits in the low bits: {adc8, adc4, adc2, adc1}
    typedef struct packed {
        logic [ADC_DATA_W-1:0] ch3;
        logic [ADC_DATA_W-1:0] ch2;
        logic [ADC_DATA_W-1:0] ch1;
        logic [ADC_DATA_W-1:0] ch0;
    } cap_word_t;

endpackage

// File: rtl/adc_capture_if.sv
// Readout stream from the capture buffer to the host: data, valid, ready, last.
// Master drives data/valid/last, slave drives ready.
interface adc_capture_if
    import adc_pkg::*;
#(
    parameter int DATA_W = ADC_DATA_W
) ();

    logic [NUM_CH*DATA_W-1:0] m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Latency: 1 cycle read. Backpressure: none, the caller gates re_i.
module capture_ram #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WIDTH      = 64
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  re_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/adc_capture.sv
// Triggered block capture of the 4-channel ADC stream into RAM, then streamed out.
// Latency: first word valid 2 cycles after READOUT entry, then 1 word/cycle.
// Backpressure: m_ready stalls hold the output; skid entry absorbs the in-flight read.
// Optional: ADC_CAPTURE_TESTPAT_EN stores a counter pattern instead of live samples.
module adc_capture
    import adc_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = ADC_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  aligned,
    input  logic [DATA_W-1:0]     adc1,
    input  logic [DATA_W-1:0]     adc2,
    input  logic [DATA_W-1:0]     adc4,
    input  logic [DATA_W-1:0]     adc8,
    input  logic                  arm,
    input  logic                  trig_sw,
    input  logic [1:0]            trig_ch,
    input  logic [DATA_W-1:0]     trig_level,
    input  logic                  trig_lvl_en,
    input  logic [DEPTH_LOG2-1:0] cap_len,
    adc_capture_if.master         m,
    output logic                  busy,
    output logic                  err
);

    localparam int WORD_W = NUM_CH * DATA_W;

    cap_state_t            state_q;
    logic [DEPTH_LOG2-1:0] len_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic                  rd_done_q;
    logic                  first_q;
    logic [DATA_W-1:0]     prev_q;
    logic                  err_q;

    logic                  ram_vld_q;
    logic                  ram_last_q;
    logic                  out_vld_q,  out_vld_d;
    logic                  out_last_q, out_last_d;
    logic [WORD_W-1:0]     out_dat_q,  out_dat_d;
    logic                  skid_vld_q,  skid_vld_d;
    logic                  skid_last_q, skid_last_d;
    logic [WORD_W-1:0]     skid_dat_q,  skid_dat_d;

    logic [DATA_W-1:0]     sel_smp;
    logic                  lvl_hit;
    logic                  trig;
    logic [WORD_W-1:0]     wr_word;
    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic [WORD_W-1:0]     ram_rdata;
    logic                  pop;
    logic [1:0]            occ;
    logic                  rd_en;

    always_comb begin
        sel_smp = adc1;
        case (trig_ch)
            2'd0:    sel_smp = adc1;
            2'd1:    sel_smp = adc2;
            2'd2:    sel_smp = adc4;
            default: sel_smp = adc8;
        endcase
    end

    // first_q masks the stale prev_q on the first ARMED cycle
    assign lvl_hit = trig_lvl_en && !first_q && (prev_q < trig_level) && (sel_smp >= trig_level);
    assign trig    = trig_sw || lvl_hit;

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [15:0] tp_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tp_cnt_q <= 16'd0;
        end else begin
            tp_cnt_q <= tp_cnt_q + 16'd1;
        end
    end

    assign wr_word = {DATA_W'(tp_cnt_q + 16'd3), DATA_W'(tp_cnt_q + 16'd2),
                      DATA_W'(tp_cnt_q + 16'd1), DATA_W'(tp_cnt_q)};
`else
    assign wr_word = {adc8, adc4, adc2, adc1};
`endif

    assign wr_en   = aligned && ((state_q == ARMED && trig) || state_q == CAPTURE);
    assign wr_addr = (state_q == CAPTURE) ? wr_ptr_q : '0;

    // A read is issued only if its word is sure to find room in out/skid next cycle
    assign pop   = out_vld_q && m.m_ready;
    assign occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q};
    assign rd_en = (state_q == READOUT) && !rd_done_q && (occ <= 2'd1 + {1'b0, pop});

    capture_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WORD_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_word),
        .re_i    (rd_en),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        out_vld_d   = out_vld_q && !pop;
        out_dat_d   = out_dat_q;
        out_last_d  = out_last_q;
        skid_vld_d  = 1'b0;
        skid_dat_d  = skid_dat_q;
        skid_last_d = skid_last_q;
        if (!out_vld_d) begin
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                out_last_d = skid_last_q;
                if (ram_vld_q) begin
                    skid_vld_d  = 1'b1;
                    skid_dat_d  = ram_rdata;
                    skid_last_d = ram_last_q;
                end
            end else if (ram_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = ram_rdata;
                out_last_d = ram_last_q;
            end
        end else if (skid_vld_q) begin
            skid_vld_d = 1'b1;
        end else if (ram_vld_q) begin
            skid_vld_d  = 1'b1;
            skid_dat_d  = ram_rdata;
            skid_last_d = ram_last_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_done_q   <= 1'b0;
            first_q     <= 1'b0;
            prev_q      <= '0;
            err_q       <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            out_dat_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            skid_dat_q  <= '0;
        end else begin
            prev_q      <= sel_smp;
            first_q     <= 1'b0;
            ram_vld_q   <= rd_en;
            ram_last_q  <= rd_en && (rd_ptr_q == len_q);
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            out_dat_q   <= out_dat_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            skid_dat_q  <= skid_dat_d;
            case (state_q)
                IDLE: begin
                    if (arm && aligned) begin
                        state_q   <= ARMED;
                        err_q     <= 1'b0;
                        len_q     <= cap_len;
                        first_q   <= 1'b1;
                        wr_ptr_q  <= '0;
                        rd_ptr_q  <= '0;
                        rd_done_q <= 1'b0;
                    end else if (arm) begin
                        err_q <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!aligned) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (trig) begin
                        wr_ptr_q <= DEPTH_LOG2'(1);
                        state_q  <= (len_q == '0) ? READOUT : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (!aligned) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                    end else if (wr_ptr_q == len_q) begin
                        state_q <= READOUT;
                    end else begin
                        wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                    end
                end
                READOUT: begin
                    if (rd_en) begin
                        rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
                        if (rd_ptr_q == len_q) begin
                            rd_done_q <= 1'b1;
                        end
                    end
                    if (pop && out_last_q) begin
                        state_q    <= IDLE;
                        out_vld_q  <= 1'b0;
                        skid_vld_q <= 1'b0;
                        ram_vld_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m.m_data  = out_dat_q;
    assign m.m_valid = out_vld_q;
    assign m.m_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;

endmodule

// File: tb/tb_adc_capture.sv
// Scoreboard bench for adc_capture: expected words are queued as samples are driven
// and compared whenever the stream presents a word.
module tb_adc_capture;
    import adc_pkg::*;

    localparam int DW = 16;
    localparam int DL = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          aligned;
    logic [DW-1:0] adc1, adc2, adc4, adc8;
    logic          arm, trig_sw, trig_lvl_en;
    logic [1:0]    trig_ch;
    logic [DW-1:0] trig_level;
    logic [DL-1:0] cap_len;
    logic          busy, err;

    adc_capture_if #(.DATA_W(DW)) mif ();

    adc_capture #(.DEPTH_LOG2(DL), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .aligned     (aligned),
        .adc1        (adc1),
        .adc2        (adc2),
        .adc4        (adc4),
        .adc8        (adc8),
        .arm         (arm),
        .trig_sw     (trig_sw),
        .trig_ch     (trig_ch),
        .trig_level  (trig_level),
        .trig_lvl_en (trig_lvl_en),
        .cap_len     (cap_len),
        .m           (mif),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        cap_word_t dat;
        logic      last;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

`ifdef ADC_CAPTURE_TESTPAT_EN
    logic [15:0] tp_cnt_m;
    always @(posedge clk) begin
        if (!rst_n) tp_cnt_m <= 16'd0;
        else        tp_cnt_m <= tp_cnt_m + 16'd1;
    end
`endif

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic cap_word_t cur_word();
        cap_word_t w;
`ifdef ADC_CAPTURE_TESTPAT_EN
        w.ch0 = tp_cnt_m;
        w.ch1 = tp_cnt_m + 16'd1;
        w.ch2 = tp_cnt_m + 16'd2;
        w.ch3 = tp_cnt_m + 16'd3;
`else
        w.ch0 = adc1;
        w.ch1 = adc2;
        w.ch2 = adc4;
        w.ch3 = adc8;
`endif
        return w;
    endfunction

    // Stream monitor: every presented word must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && mif.m_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_valid", 64'(mif.m_valid), 64'd0);
            end else begin
                check_eq("m_data", mif.m_data, sb[0].dat);
                check_eq("m_last", 64'(mif.m_last), 64'(sb[0].last));
                if (mif.m_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_adc();
        adc1 = 16'($urandom);
        adc2 = 16'($urandom);
        adc4 = 16'($urandom);
        adc8 = 16'($urandom);
    endtask

    task automatic arm_it();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Drives the trigger cycle plus len further capture cycles; queues expectations
    task automatic capture(input int len, input bit sw);
        for (int i = 0; i <= len; i++) begin
            rand_adc();
            if (i == 0 && !sw) adc4 = 16'h8000;
            trig_sw = sw && (i == 0);
            sb.push_back('{cur_word(), (i == len)});
            tick();
        end
        trig_sw = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget, input bit bp);
        int k = 0;
        while (k < budget && (sb.size() != 0 || busy)) begin
            mif.m_ready = bp ? (k % 3 == 0) : 1'b1;
            rand_adc();
            tick();
            k++;
        end
        mif.m_ready = 1'b1;
        check_eq({tag, "_left"}, 64'(sb.size()), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_vld"}, 64'(mif.m_valid), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; aligned = 1'b0; arm = 1'b0; trig_sw = 1'b0;
        trig_ch = 2'd0; trig_level = '0; trig_lvl_en = 1'b0; cap_len = '0;
        adc1 = '0; adc2 = '0; adc4 = '0; adc8 = '0;
        mif.m_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid", 64'(mif.m_valid), 64'd0);
        check_eq("rst_last",  64'(mif.m_last),  64'd0);
        check_eq("rst_data",  mif.m_data,       64'd0);
        check_eq("rst_busy",  64'(busy),        64'd0);
        check_eq("rst_err",   64'(err),         64'd0);
        rst_n = 1'b1;
        aligned = 1'b1;
        mif.m_ready = 1'b1;
        tick();

        // Software trigger, 8 words, readout latency
        cap_len = 10'd7;
        arm_it();
        check_eq("sw_busy_armed", 64'(busy), 64'd1);
        repeat (5) begin rand_adc(); tick(); end
        capture(7, 1'b1);
        check_eq("lat_r0", 64'(mif.m_valid), 64'd0);
        tick();
        check_eq("lat_r1", 64'(mif.m_valid), 64'd0);
        tick();
        check_eq("lat_r2", 64'(mif.m_valid), 64'd1);
        drain("sw", 100, 1'b0);

        // Level trigger on adc4: held high level must not fire, rising crossing does
        trig_ch = 2'd2; trig_level = 16'h8000; trig_lvl_en = 1'b1; cap_len = 10'd3;
        rand_adc(); adc4 = 16'h9000; tick();
        rand_adc(); adc4 = 16'h9000; arm_it();
        repeat (4) begin rand_adc(); adc4 = 16'h9000; tick(); end
        rand_adc(); adc4 = 16'h7FFE; tick();
        rand_adc(); adc4 = 16'h7FFF; tick();
        capture(3, 1'b0);
        drain("lvl", 100, 1'b0);
        trig_lvl_en = 1'b0;

        // Backpressure: 1,0,0 ready pattern
        cap_len = 10'd3;
        arm_it();
        capture(3, 1'b1);
        drain("bp", 100, 1'b1);

        // Alignment loss at capture word 3
        cap_len = 10'd7;
        arm_it();
        for (int i = 0; i < 4; i++) begin
            rand_adc();
            trig_sw = (i == 0);
            aligned = (i != 3);
            tick();
        end
        trig_sw = 1'b0;
        check_eq("al_busy", 64'(busy), 64'd0);
        check_eq("al_err",  64'(err),  64'd1);
        aligned = 1'b1;
        repeat (10) begin rand_adc(); tick(); end
        check_eq("al_novalid", 64'(mif.m_valid), 64'd0);
        arm_it();
        check_eq("al_err_clr", 64'(err),  64'd0);
        check_eq("al_rearm",   64'(busy), 64'd1);

        // Reset while word 2 is presented
        capture(7, 1'b1);
        begin
            int k = 0;
            while (k < 100 && sb.size() != 6) begin rand_adc(); tick(); k++; end
            check_eq("rr_reach_w2", 64'(sb.size()), 64'd6);
        end
        mif.m_ready = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        check_eq("rr_valid", 64'(mif.m_valid), 64'd0);
        check_eq("rr_busy",  64'(busy),        64'd0);
        mif.m_ready = 1'b1;
        aligned = 1'b0;
        arm_it();
        check_eq("idle_arm_unaligned_err", 64'(err), 64'd1);
        check_eq("idle_arm_unaligned_busy", 64'(busy), 64'd0);
        aligned = 1'b1;
        cap_len = 10'd0;
        arm_it();
        capture(0, 1'b1);
        drain("one", 100, 1'b0);
        cap_len = 10'd2;
        arm_it();
        capture(2, 1'b1);
        drain("post_rst", 100, 1'b0);

`ifdef ADC_CAPTURE_TESTPAT_EN
        cap_len = 10'd1023;
        arm_it();
        capture(1023, 1'b1);
        drain("tp", 3000, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
